// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: base opcodes, branch funct3 codes and
// the immediate-format selector used by the decode stage.
package riscv_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_B = 3'd2,
      IMM_U = 3'd3,
      IMM_J = 3'd4,
      IMM_R = 3'd5
   } imm_fmt_t;

endpackage

// File: rtl/decode_unit_imm_gen.sv
// Combinational RV32I immediate generator; the R format (and anything
// without an immediate) yields zero.
module imm_gen
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     i_inst,
   input  imm_fmt_t        i_fmt,
   output logic [XLEN-1:0] o_imm
);

   logic [31:0] w_imm32;

   // Assemble the 32-bit immediate for the selected format, then sign-extend.
   always_comb begin
      w_imm32 = 32'd0;
      case (i_fmt)
         IMM_I:   w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
         IMM_S:   w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
         IMM_B:   w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                             i_inst[30:25], i_inst[11:8], 1'b0};
         IMM_U:   w_imm32 = {i_inst[31:12], 12'd0};
         IMM_J:   w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                             i_inst[20], i_inst[30:21], 1'b0};
         default: w_imm32 = 32'd0;
      endcase
      o_imm = XLEN'($signed(w_imm32));
   end

endmodule

// File: rtl/decode_unit.sv
// Registered RV32I decode stage: operand forwarding, load-use stall,
// optional in-stage jump/branch resolution with a one-cycle fetch redirect.
module decode_unit
   import riscv_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int NFWD         = 2,
   parameter int BRANCH_IN_ID = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [XLEN-1:0]    in_pc,
   input  logic [31:0]        in_inst,
   output logic [4:0]         rf_raddr1,
   output logic [4:0]         rf_raddr2,
   input  logic [XLEN-1:0]    rf_rdata1,
   input  logic [XLEN-1:0]    rf_rdata2,
   input  logic [NFWD-1:0]    fwd_valid,
   input  logic [5*NFWD-1:0]  fwd_addr,
   input  logic [XLEN*NFWD-1:0] fwd_data,
   input  logic [NFWD-1:0]    fwd_pending,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [XLEN-1:0]    out_pc,
   output logic [XLEN-1:0]    out_rs1_val,
   output logic [XLEN-1:0]    out_rs2_val,
   output logic [XLEN-1:0]    out_imm,
   output logic [6:0]         out_opcode,
   output logic [2:0]         out_funct3,
   output logic               out_funct7b5,
   output logic [4:0]         out_rd,
   output logic               out_wreg,
   output logic               out_illegal,
   output logic               redirect_valid,
   output logic [XLEN-1:0]    redirect_addr
);

   logic [6:0]      w_opcode;
   logic [2:0]      w_funct3;
   logic [4:0]      w_rs1, w_rs2, w_rd;
   logic            w_rd1_en, w_rd2_en, w_wr_en, w_illegal;
   imm_fmt_t        w_fmt;
   logic [XLEN-1:0] w_imm, w_a, w_b, w_pc_tgt, w_jalr_sum, w_target;
   logic [XLEN:0]   w_sel1, w_sel2;
   logic            w_hazard, w_accept, w_taken, w_redirect_en;

   logic            r_valid, r_redirect, r_funct7b5, r_wreg, r_illegal;
   logic [XLEN-1:0] r_pc, r_rs1, r_rs2, r_imm, r_redirect_addr;
   logic [6:0]      r_opcode;
   logic [2:0]      r_funct3;
   logic [4:0]      r_rd;

   // Returns {pending, value}; lowest-indexed (youngest) matching source wins.
   function automatic logic [XLEN:0] select_operand(
      input logic [4:0]             rs,
      input logic                   en,
      input logic [XLEN-1:0]        rf,
      input logic [NFWD-1:0]        fv,
      input logic [5*NFWD-1:0]      fa,
      input logic [XLEN*NFWD-1:0]   fd,
      input logic [NFWD-1:0]        fp
   );
      logic [XLEN:0] sel;
      sel = {1'b0, rf};
      for (int k = NFWD - 1; k >= 0; k--) begin
         sel = (fv[k] && (fa[5*k +: 5] == rs)) ? {fp[k], fd[XLEN*k +: XLEN]} : sel;
      end
      return (en && (rs != 5'd0)) ? sel : {(XLEN+1){1'b0}};
   endfunction

   assign w_opcode  = in_inst[6:0];
   assign w_rd      = in_inst[11:7];
   assign w_funct3  = in_inst[14:12];
   assign w_rs1     = in_inst[19:15];
   assign w_rs2     = in_inst[24:20];
   assign rf_raddr1 = w_rs1;
   assign rf_raddr2 = w_rs2;

   // Opcode classification: which ports are read, rd write, immediate format.
   always_comb begin
      w_rd1_en  = 1'b0;
      w_rd2_en  = 1'b0;
      w_wr_en   = 1'b0;
      w_illegal = 1'b0;
      w_fmt     = IMM_R;
      case (w_opcode)
         OPC_LUI:    begin w_fmt = IMM_U; w_wr_en = 1'b1; end
         OPC_AUIPC:  begin w_fmt = IMM_U; w_wr_en = 1'b1; end
         OPC_JAL:    begin w_fmt = IMM_J; w_wr_en = 1'b1; end
         OPC_JALR:   begin w_fmt = IMM_I; w_rd1_en = 1'b1; w_wr_en = 1'b1; end
         OPC_BRANCH: begin w_fmt = IMM_B; w_rd1_en = 1'b1; w_rd2_en = 1'b1; end
         OPC_LOAD:   begin w_fmt = IMM_I; w_rd1_en = 1'b1; w_wr_en = 1'b1; end
         OPC_STORE:  begin w_fmt = IMM_S; w_rd1_en = 1'b1; w_rd2_en = 1'b1; end
         OPC_OPIMM:  begin w_fmt = IMM_I; w_rd1_en = 1'b1; w_wr_en = 1'b1; end
         OPC_OP:     begin w_fmt = IMM_R; w_rd1_en = 1'b1; w_rd2_en = 1'b1; w_wr_en = 1'b1; end
         default:    w_illegal = 1'b1;
      endcase
   end

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .i_inst (in_inst),
      .i_fmt  (w_fmt),
      .o_imm  (w_imm)
   );

   assign w_sel1 = select_operand(w_rs1, w_rd1_en, rf_rdata1, fwd_valid, fwd_addr, fwd_data, fwd_pending);
   assign w_sel2 = select_operand(w_rs2, w_rd2_en, rf_rdata2, fwd_valid, fwd_addr, fwd_data, fwd_pending);
   assign w_a    = w_sel1[XLEN-1:0];
   assign w_b    = w_sel2[XLEN-1:0];

   assign w_hazard = in_valid && (w_sel1[XLEN] || w_sel2[XLEN]);
   // During the redirect cycle the stage swallows the wrong-path offer.
   assign in_ready = !rst && !flush && (r_redirect || (!w_hazard && (!r_valid || out_ready)));
   assign w_accept = in_valid && in_ready && !r_redirect;

   // Jump/branch resolution from the selected operands.
   always_comb begin
      w_pc_tgt   = in_pc + w_imm;
      w_jalr_sum = w_a + w_imm;
      w_target   = w_pc_tgt;
      w_taken    = 1'b0;
      case (w_opcode)
         OPC_JAL:  w_taken = 1'b1;
         OPC_JALR: begin
            w_taken  = 1'b1;
            w_target = {w_jalr_sum[XLEN-1:1], 1'b0};
         end
         OPC_BRANCH: begin
            case (w_funct3)
               F3_BEQ:  w_taken = (w_a == w_b);
               F3_BNE:  w_taken = (w_a != w_b);
               F3_BLT:  w_taken = ($signed(w_a) <  $signed(w_b));
               F3_BGE:  w_taken = ($signed(w_a) >= $signed(w_b));
               F3_BLTU: w_taken = (w_a <  w_b);
               F3_BGEU: w_taken = (w_a >= w_b);
               default: w_taken = 1'b0;
            endcase
         end
         default: w_taken = 1'b0;
      endcase
   end

   assign w_redirect_en = (BRANCH_IN_ID != 0) && w_taken;

   // Output pipe register; flush outranks redirect squash, which outranks accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid         <= 1'b0;
         r_redirect      <= 1'b0;
         r_redirect_addr <= '0;
         r_pc            <= '0;
         r_rs1           <= '0;
         r_rs2           <= '0;
         r_imm           <= '0;
         r_opcode        <= 7'd0;
         r_funct3        <= 3'd0;
         r_funct7b5      <= 1'b0;
         r_rd            <= 5'd0;
         r_wreg          <= 1'b0;
         r_illegal       <= 1'b0;
      end else if (flush) begin
         r_valid    <= 1'b0;
         r_redirect <= 1'b0;
      end else if (r_redirect) begin
         r_redirect <= 1'b0;
         if (out_ready) begin
            r_valid <= 1'b0;
         end
      end else if (w_accept) begin
         r_valid         <= 1'b1;
         r_redirect      <= w_redirect_en;
         r_redirect_addr <= w_target;
         r_pc            <= in_pc;
         r_rs1           <= w_a;
         r_rs2           <= w_b;
         r_imm           <= w_imm;
         r_opcode        <= w_opcode;
         r_funct3        <= w_funct3;
         r_funct7b5      <= in_inst[30];
         r_rd            <= w_rd;
         r_wreg          <= w_wr_en && (w_rd != 5'd0);
         r_illegal       <= w_illegal;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign out_valid      = r_valid;
   assign out_pc         = r_pc;
   assign out_rs1_val    = r_rs1;
   assign out_rs2_val    = r_rs2;
   assign out_imm        = r_imm;
   assign out_opcode     = r_opcode;
   assign out_funct3     = r_funct3;
   assign out_funct7b5   = r_funct7b5;
   assign out_rd         = r_rd;
   assign out_wreg       = r_wreg;
   assign out_illegal    = r_illegal;
   assign redirect_valid = r_redirect;
   assign redirect_addr  = r_redirect_addr;

endmodule

// File: tb/tb_decode_unit.sv
// Directed and randomized bench for decode_unit with an ISA-level reference
// model (register array + forwarding list) computing every expected value.
module tb_decode_unit;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_ready;
   logic [31:0] in_pc, in_inst, rf_rdata1, rf_rdata2;
   logic [4:0]  rf_raddr1, rf_raddr2;
   logic [1:0]  fwd_valid, fwd_pending;
   logic [9:0]  fwd_addr;
   logic [63:0] fwd_data;
   logic        out_valid, out_funct7b5, out_wreg, out_illegal, redirect_valid;
   logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm, redirect_addr;
   logic [6:0]  out_opcode;
   logic [2:0]  out_funct3;
   logic [4:0]  out_rd;

   logic [31:0] regs [32];
   logic        fv [2];
   logic [4:0]  fa [2];
   logic [31:0] fd [2];
   logic        fp [2];

   int checks = 0;
   int failures = 0;

   logic [31:0] e_a, e_b, e_imm, e_target;
   logic        e_taken, e_wreg, e_ill;

   always #5 clk = ~clk;

   assign rf_rdata1   = regs[in_inst[19:15]];
   assign rf_rdata2   = regs[in_inst[24:20]];
   assign fwd_valid   = {fv[1], fv[0]};
   assign fwd_pending = {fp[1], fp[0]};
   assign fwd_addr    = {fa[1], fa[0]};
   assign fwd_data    = {fd[1], fd[0]};

   decode_unit #(.XLEN(32), .NFWD(2), .BRANCH_IN_ID(1)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
      .fwd_pending(fwd_pending),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
      .out_imm(out_imm), .out_opcode(out_opcode), .out_funct3(out_funct3),
      .out_funct7b5(out_funct7b5), .out_rd(out_rd), .out_wreg(out_wreg),
      .out_illegal(out_illegal),
      .redirect_valid(redirect_valid), .redirect_addr(redirect_addr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      flush    = 1'b0;
      for (int k = 0; k < 2; k++) begin
         fv[k] = 1'b0; fp[k] = 1'b0; fa[k] = 5'd0; fd[k] = 32'd0;
      end
   endtask

   task automatic offer(input logic [31:0] pc, input logic [31:0] inst);
      in_pc    = pc;
      in_inst  = inst;
      in_valid = 1'b1;
   endtask

   // Architectural operand value: x0 is zero, else youngest forwarder, else regfile.
   function automatic logic [31:0] operand(input logic [4:0] rs);
      if (rs == 5'd0) return 32'd0;
      for (int k = 0; k < 2; k++)
         if (fv[k] && fa[k] == rs) return fd[k];
      return regs[rs];
   endfunction

   task automatic compute();
      logic [6:0] op;
      logic       r1, r2;
      int         v;
      op    = in_inst[6:0];
      e_ill = !(op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33});
      r1    = !e_ill && !(op inside {7'h37, 7'h17, 7'h6F});
      r2    = op inside {7'h63, 7'h23, 7'h33};
      e_a   = r1 ? operand(in_inst[19:15]) : 32'd0;
      e_b   = r2 ? operand(in_inst[24:20]) : 32'd0;
      case (op)
         7'h37, 7'h17: v = int'(in_inst[31:12]) * 4096;
         7'h67, 7'h03, 7'h13: begin
            v = int'(in_inst[31:20]);
            if (v >= 2048) v = v - 4096;
         end
         7'h23: begin
            v = int'(in_inst[31:25]) * 32 + int'(in_inst[11:7]);
            if (v >= 2048) v = v - 4096;
         end
         7'h63: begin
            v = int'(in_inst[31]) * 4096 + int'(in_inst[7]) * 2048
              + int'(in_inst[30:25]) * 32 + int'(in_inst[11:8]) * 2;
            if (v >= 4096) v = v - 8192;
         end
         7'h6F: begin
            v = int'(in_inst[31]) * 1048576 + int'(in_inst[19:12]) * 4096
              + int'(in_inst[20]) * 2048 + int'(in_inst[30:21]) * 2;
            if (v >= 1048576) v = v - 2097152;
         end
         default: v = 0;
      endcase
      e_imm    = 32'(v);
      e_wreg   = !e_ill && !(op inside {7'h63, 7'h23}) && (in_inst[11:7] != 5'd0);
      e_target = in_pc + e_imm;
      e_taken  = 1'b0;
      if (op == 7'h6F) e_taken = 1'b1;
      if (op == 7'h67) begin
         e_taken  = 1'b1;
         e_target = (e_a + e_imm) & 32'hFFFF_FFFE;
      end
      if (op == 7'h63) begin
         case (in_inst[14:12])
            3'd0: e_taken = (e_a == e_b);
            3'd1: e_taken = (e_a != e_b);
            3'd4: e_taken = (int'(e_a) <  int'(e_b));
            3'd5: e_taken = (int'(e_a) >= int'(e_b));
            3'd6: e_taken = (e_a <  e_b);
            3'd7: e_taken = (e_a >= e_b);
            default: e_taken = 1'b0;
         endcase
      end
   endtask

   // Compare the registered payload against the model of the offered instruction.
   task automatic check_accepted(input string tag, input logic [31:0] pc, input logic [31:0] inst);
      chk({tag, ".valid"},   32'(out_valid), 32'd1);
      chk({tag, ".pc"},      out_pc, pc);
      chk({tag, ".rs1"},     out_rs1_val, e_a);
      chk({tag, ".rs2"},     out_rs2_val, e_b);
      chk({tag, ".imm"},     out_imm, e_imm);
      chk({tag, ".opcode"},  32'(out_opcode), 32'(inst[6:0]));
      chk({tag, ".funct3"},  32'(out_funct3), 32'(inst[14:12]));
      chk({tag, ".f7b5"},    32'(out_funct7b5), 32'(inst[30]));
      chk({tag, ".rd"},      32'(out_rd), 32'(inst[11:7]));
      chk({tag, ".wreg"},    32'(out_wreg), 32'(e_wreg));
      chk({tag, ".illegal"}, 32'(out_illegal), 32'(e_ill));
      chk({tag, ".redir"},   32'(redirect_valid), 32'(e_taken));
      if (e_taken) chk({tag, ".redir_addr"}, redirect_addr, e_target);
   endtask

   initial begin
      logic [6:0]  ops [10];
      logic [31:0] ins, pcv;
      int          pick;
      ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0B};
      for (int r = 0; r < 32; r++) regs[r] = $urandom | 32'h1;
      idle();
      out_ready = 1'b1;
      rst = 1'b1;
      offer(32'h0, 32'h0050_0093);

      // Reset
      @(negedge clk);
      chk("rst.in_ready", 32'(in_ready), 32'd0);
      tick(); tick();
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.redir", 32'(redirect_valid), 32'd0);
      chk("rst.out_pc", out_pc, 32'd0);
      chk("rst.out_imm", out_imm, 32'd0);
      chk("rst.out_wreg", 32'(out_wreg), 32'd0);
      rst = 1'b0;
      idle();
      tick();

      // Back-to-back: ADDI x1,x0,5 then ADD x2,x1,x1 forwarding x1=5
      offer(32'h100, 32'h0050_0093);
      @(negedge clk);
      chk("b2b.ready0", 32'(in_ready), 32'd1);
      chk("b2b.raddr1", 32'(rf_raddr1), 32'd0);
      compute();
      tick();
      check_accepted("addi", 32'h100, 32'h0050_0093);
      chk("addi.imm5", out_imm, 32'd5);
      regs[1] = 32'h77;
      offer(32'h104, 32'h0010_8133);
      fv[0] = 1'b1; fa[0] = 5'd1; fd[0] = 32'd5;
      @(negedge clk);
      chk("b2b.ready1", 32'(in_ready), 32'd1);
      compute();
      tick();
      check_accepted("add", 32'h104, 32'h0010_8133);
      chk("add.rs1_fwd", out_rs1_val, 32'd5);
      chk("add.rs2_fwd", out_rs2_val, 32'd5);

      // Load-use: ADD x4,x3,x0 with x3 pending on youngest source
      offer(32'h108, 32'h0001_8233);
      fv[0] = 1'b1; fa[0] = 5'd3; fp[0] = 1'b1; fd[0] = 32'h0;
      fv[1] = 1'b1; fa[1] = 5'd3; fp[1] = 1'b0; fd[1] = 32'h1111;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("lu.stall_ready", 32'(in_ready), 32'd0);
         tick();
         chk("lu.bubble", 32'(out_valid), 32'd0);
      end
      fp[0] = 1'b0; fd[0] = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("lu.release_ready", 32'(in_ready), 32'd1);
      compute();
      tick();
      check_accepted("lu", 32'h108, 32'h0001_8233);
      chk("lu.fwd_data", out_rs1_val, 32'hDEAD_BEEF);
      chk("lu.rs2_x0", out_rs2_val, 32'd0);
      idle();

      // BGE x5,x6,+16 with both -1: taken (equal)
      regs[5] = 32'hFFFF_FFFF; regs[6] = 32'hFFFF_FFFF;
      offer(32'h200, 32'h0062_D863);
      compute();
      tick();
      check_accepted("bge", 32'h200, 32'h0062_D863);
      chk("bge.taken", 32'(redirect_valid), 32'd1);
      chk("bge.target", redirect_addr, 32'h210);
      idle();
      tick();
      chk("bge.pulse", 32'(redirect_valid), 32'd0);
      chk("bge.drain", 32'(out_valid), 32'd0);

      // BGEU x7,x8 with 1 vs 0xFFFFFFFF: not taken
      regs[7] = 32'd1; regs[8] = 32'hFFFF_FFFF;
      offer(32'h300, 32'h0083_F863);
      compute();
      tick();
      check_accepted("bgeu", 32'h300, 32'h0083_F863);
      chk("bgeu.not_taken", 32'(redirect_valid), 32'd0);

      // JALR x1,2(x9) with x9=0x1003, next offer squashed
      regs[9] = 32'h1003;
      offer(32'h400, 32'h0024_80E7);
      compute();
      tick();
      check_accepted("jalr", 32'h400, 32'h0024_80E7);
      chk("jalr.target", redirect_addr, 32'h1004);
      offer(32'h404, 32'h0050_0093);
      @(negedge clk);
      chk("jalr.squash_ready", 32'(in_ready), 32'd1);
      tick();
      chk("jalr.squash_valid", 32'(out_valid), 32'd0);
      chk("jalr.pulse", 32'(redirect_valid), 32'd0);
      idle();

      // Flush collides with taken JAL x1,+8
      offer(32'h500, 32'h0080_00EF);
      flush = 1'b1;
      @(negedge clk);
      chk("flush.ready", 32'(in_ready), 32'd0);
      tick();
      chk("flush.redir", 32'(redirect_valid), 32'd0);
      chk("flush.valid", 32'(out_valid), 32'd0);
      flush = 1'b0;

      // Redirect with out_ready low: jump held, pulse still one cycle
      offer(32'h600, 32'h0080_00EF);
      compute();
      tick();
      check_accepted("jal", 32'h600, 32'h0080_00EF);
      chk("jal.target", redirect_addr, 32'h608);
      out_ready = 1'b0;
      offer(32'h604, 32'h0050_0093);
      @(negedge clk);
      chk("hold.ready", 32'(in_ready), 32'd1);
      tick();
      chk("hold.redir", 32'(redirect_valid), 32'd0);
      chk("hold.valid", 32'(out_valid), 32'd1);
      chk("hold.pc", out_pc, 32'h600);
      out_ready = 1'b1;
      idle();
      tick();
      chk("hold.drain", 32'(out_valid), 32'd0);

      // Back-pressure for 3 cycles
      offer(32'h700, 32'h0050_0093);
      compute();
      tick();
      check_accepted("bp", 32'h700, 32'h0050_0093);
      out_ready = 1'b0;
      offer(32'h704, 32'h0010_8133);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("bp.ready", 32'(in_ready), 32'd0);
         tick();
         chk("bp.pc", out_pc, 32'h700);
         chk("bp.imm", out_imm, 32'd5);
         chk("bp.valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp.release", 32'(in_ready), 32'd1);
      compute();
      tick();
      check_accepted("bp2", 32'h704, 32'h0010_8133);

      // Illegal opcode 0x7F with rd=31
      offer(32'h800, 32'h0000_0FFF);
      compute();
      tick();
      check_accepted("ill", 32'h800, 32'h0000_0FFF);
      chk("ill.flag", 32'(out_illegal), 32'd1);
      chk("ill.wreg", 32'(out_wreg), 32'd0);

      // x0 never matches a forwarder
      offer(32'h804, 32'h0000_0233);
      fv[0] = 1'b1; fa[0] = 5'd0; fd[0] = 32'd123;
      compute();
      tick();
      chk("x0.rs1", out_rs1_val, 32'd0);
      chk("x0.rs2", out_rs2_val, 32'd0);
      idle();

      // Hazard with stalled output, then reset mid-stall
      offer(32'h900, 32'h0050_0093);
      tick();
      out_ready = 1'b0;
      offer(32'h904, 32'h0001_8233);
      fv[0] = 1'b1; fa[0] = 5'd3; fp[0] = 1'b1;
      tick();
      chk("hz.held_valid", 32'(out_valid), 32'd1);
      chk("hz.held_pc", out_pc, 32'h900);
      rst = 1'b1;
      tick();
      chk("rst_mid.valid", 32'(out_valid), 32'd0);
      rst = 1'b0;
      idle();
      out_ready = 1'b1;
      tick();
      chk("rst_mid.empty", 32'(out_valid), 32'd0);

      // Randomized single-issue instructions against the model
      for (int it = 0; it < 200; it++) begin
         for (int r = 0; r < 32; r++) regs[r] = $urandom;
         ins = $urandom;
         ins[6:0] = ops[$urandom_range(0, 9)];
         pcv = $urandom;
         pcv[1:0] = 2'b00;
         for (int k = 0; k < 2; k++) begin
            fv[k] = 1'($urandom_range(0, 1));
            pick  = $urandom_range(0, 2);
            fa[k] = (pick == 0) ? ins[19:15] : (pick == 1) ? ins[24:20] : 5'($urandom);
            fd[k] = $urandom;
            fp[k] = 1'b0;
         end
         offer(pcv, ins);
         @(negedge clk);
         chk("rnd.ready", 32'(in_ready), 32'd1);
         chk("rnd.raddr1", 32'(rf_raddr1), 32'(ins[19:15]));
         chk("rnd.raddr2", 32'(rf_raddr2), 32'(ins[24:20]));
         compute();
         tick();
         check_accepted("rnd", pcv, ins);
         idle();
         tick();
         chk("rnd.drain", 32'(out_valid), 32'd0);
         chk("rnd.pulse", 32'(redirect_valid), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decode_unit.md
# decode_unit

Parametrised, registered RV32I instruction-decode stage sitting between the IF/ID pipe register and the execute stage. It decodes the opcode, generates the immediate and selects operands from the register file or from NFWD forwarding ports. It detects load-use hazards and stalls on them. When enabled, it resolves jumps and branches, issuing a one-cycle redirect to fetch. Input and output both use valid/ready handshakes, and a flush input cancels in-flight work.

## Interface
- XLEN, 32, datapath width; immediates sign-extended to XLEN.
- NFWD, 2, number of forwarding sources; index 0 is youngest and has highest priority.
- BRANCH_IN_ID, 1, 1 = resolve JAL/JALR/B-type here; 0 = pass through, redirect_valid tied 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  kill everything in the stage this cycle.
- in_valid  in  1  instruction offered.
- in_ready  out  1  stage accepts this cycle.
- in_pc  in  XLEN  instruction address.
- in_inst  in  32  instruction word.
- rf_raddr1 / rf_raddr2  out  5  combinational = inst[19:15] / inst[24:20].
- rf_rdata1 / rf_rdata2  in  XLEN  regfile read data, same cycle.
- fwd_valid  in  NFWD  source k carries a register write.
- fwd_addr  in  5*NFWD  destination of source k.
- fwd_data  in  XLEN*NFWD  write data of source k.
- fwd_pending  in  NFWD  source k is a load whose data is not yet available.
- out_valid  out  1  decoded instruction present.
- out_ready  in  1  execute consumes.
- out_pc, out_rs1_val, out_rs2_val, out_imm  out  XLEN  registered payload.
- out_opcode  out  7;  out_funct3  out  3;  out_funct7b5  out  1;  out_rd  out  5.
- out_wreg  out  1  instruction writes rd, and rd≠0.
- out_illegal  out  1  opcode not in RV32I base set.
- redirect_valid  out  1  one-cycle pulse, fetch must restart.
- redirect_addr  out  XLEN  restart target.

## Operation
- **Decode.** Opcodes are LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP.
  - rs1 is read by every opcode except LUI, AUIPC and JAL.
  - rs2 is read only by BRANCH, STORE and OP.
  - Any other opcode sets out_illegal=1, out_wreg=0 and reads no registers.
- **Immediates.** I/S/B/U/J formats per the ISA, sign-extended to XLEN. OP produces imm=0.
- **Operand select**, per read port:
  - x0 always yields 0 and never matches a forwarding source.
  - Otherwise, take the lowest k with fwd_valid[k] && fwd_addr[k]==rs; if none matches, take rf_rdata.
  - Ports the instruction does not read yield 0.
- **Load-use hazard.** The hazard holds when the selected source for a read port has fwd_pending=1. While it holds:
  - in_ready=0;
  - nothing is captured;
  - out_valid drops to 0 once the current output is consumed (a bubble).
- **Accept.** accept = in_valid && in_ready.
  - in_ready = !rst && !flush && !hazard && (!out_valid || out_ready).
  - On accept, all out_* fields register and out_valid=1.
  - When out_ready=1 and no accept occurs, out_valid←0.
- **Branch resolution** (BRANCH_IN_ID=1), computed from the selected operands:
  - JAL target = pc + imm.
  - JALR target = (rs1 + imm) with bit0 cleared.
  - BEQ/BNE compare equality; BLT/BGE are signed; BLTU/BGEU are unsigned.
  - BGE and BGEU are "greater or equal", not strict.
  - Taken: redirect_valid=1 and redirect_addr=target, registered with the accept.
- **Wrong-path squash.** In the cycle redirect_valid=1:
  - in_ready=1;
  - any offered instruction is dropped (not captured, out_valid←0 unless out_ready=0 holds the jump).
- **Redirect hold.** redirect_valid is high for exactly one cycle. If out_ready=0, the jump stays in the output register but redirect_valid still deasserts.
- **Flush.** Flush has priority over everything. On the next edge: out_valid←0, redirect_valid←0, and the offered input is discarded.

## Timing
- Latency: 1 cycle from accept to out_valid. Throughput: 1 instruction per cycle with no hazard.
- Reset: all out_* registers, out_valid and redirect_valid are 0 on the edge after rst. in_ready=0 while rst=1.
- rf_raddr and in_ready are combinational from the inputs. All other outputs are registered.
- Simultaneous redirect and flush: flush wins and no redirect is issued.
- Hazard with output stalled: out_valid is held; the instruction is not re-captured.
- Reset mid-stall: pending state is lost and the stage is empty after reset.

## Structure
- Shared package riscv_pkg holds:
  - opcode constants;
  - branch funct3 codes (BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111);
  - an imm_fmt_t enum {I,S,B,U,J,R}.
- Sub-module imm_gen: combinational, takes inst and imm_fmt_t, outputs sign-extended XLEN imm.
- The forwarding mux, hazard logic, branch compare and output register are all inside decode_unit.

## Test plan
- **Back-to-back flow.** ADDI x1,x0,5 then ADD x2,x1,x1 with fwd0={x1,5} → second out_rs1_val=out_rs2_val=5, out_valid on consecutive cycles.
- **Load-use stall.** LW x3 pending on fwd0, then ADD x4,x3,x0 → in_ready=0 until fwd_pending drops; then captured with fwd data 0xDEADBEEF.
- **BGE boundary.**
  - rs1=rs2=-1 → redirect_valid=1, redirect_addr=pc+imm.
  - BGEU with rs1=1, rs2=0xFFFFFFFF → not taken.
- **JALR.** rs1=0x1003, imm=2 → redirect_addr=0x1004. The instruction offered the next cycle is dropped.
- **Flush/redirect collision.** flush asserted in the same cycle a taken JAL is accepted → no redirect, out_valid=0.
- **Back-pressure.**
  - out_ready=0 for 3 cycles → payload stable, in_ready=0.
  - illegal opcode 0x7F → out_illegal=1, out_wreg=0.
